// File: rtl/mmap_uart_pkg.sv
// Shared definitions for the memory-mapped UART: bus addresses, STATUS bit
// positions and the state encoding used by both serial FSMs.
package mmap_uart_pkg;

  localparam logic [15:0] ADDR_UART_DATA_MMAP   = 16'hC010;
  localparam logic [15:0] ADDR_UART_STATUS_MMAP = 16'hC014;

  localparam int UART_ST_RX_AVAIL  = 0;
  localparam int UART_ST_RX_FULL   = 1;
  localparam int UART_ST_TX_FULL   = 2;
  localparam int UART_ST_TX_IDLE   = 3;
  localparam int UART_ST_OVERRUN   = 4;
  localparam int UART_ST_FRAME_ERR = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/mmap_uart_fifo.sv
// Small synchronous FIFO with a combinational head; a push is refused when
// full even if a pop happens in the same cycle.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmap_uart.sv
// 8N1 UART with TX/RX FIFOs behind a two-register (DATA/STATUS) window.
// Handshake: a bus access is valid when sel_i is high with we_i or re_i; it always completes in one cycle.
module mmap_uart
  import mmap_uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel_i,
  input  logic        reg_i,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        rx_i,
  output logic        tx_o
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);

  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0] tx_dout;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] rx_dout;
  logic       stat_wr;
  logic       unused_wdata;

  assign tx_push      = sel_i && we_i && !reg_i;
  assign stat_wr      = sel_i && we_i && reg_i;
  assign rx_pop       = sel_i && re_i && !reg_i;
  assign unused_wdata = ^wdata_i[31:8];

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop),
    .din(wdata_i[7:0]), .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );

  // ---------------- transmitter ----------------
  uart_state_t      tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shreg;

  // A queued byte is taken at the end of the stop bit so consecutive frames abut.
  assign tx_pop = !tx_empty &&
                  ((tx_state == S_IDLE) || (tx_state == S_STOP && tx_cnt == DIV_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
      tx_o     <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (!tx_empty) begin
            tx_shreg <= tx_dout;
            tx_o     <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_o     <= tx_shreg[0];
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_o     <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx_shreg <= {1'b0, tx_shreg[7:1]};
              tx_o     <= tx_shreg[1];
              tx_bit   <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt <= '0;
            if (!tx_empty) begin
              tx_shreg <= tx_dout;
              tx_o     <= 1'b0;
              tx_state <= S_START;
            end else begin
              tx_state <= S_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic             rx_meta, rx_sync;
  uart_state_t      rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shreg;
  logic             rx_stop_smp;
  logic             frame_err, overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
    end
  end

  assign rx_stop_smp = (rx_state == S_STOP) && (rx_cnt == DIV_LAST);
  assign rx_push     = rx_stop_smp && rx_sync && !rx_full;

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop),
    .din(rx_shreg), .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shreg <= '0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          if (!rx_sync) begin
            rx_cnt   <= '0;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt   <= '0;
            rx_shreg <= {rx_sync, rx_shreg[7:1]};
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt   <= '0;
            rx_state <= S_IDLE;
          end else begin
            rx_cnt <= rx_cnt + CNT_W'(1);
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // Sticky flags: a hardware set beats a same-cycle software clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= (rx_stop_smp && !rx_sync) ||
                   (frame_err && !(stat_wr && wdata_i[UART_ST_FRAME_ERR]));
      overrun   <= (rx_stop_smp && rx_sync && rx_full) ||
                   (overrun && !(stat_wr && wdata_i[UART_ST_OVERRUN]));
    end
  end

  // ---------------- read mux ----------------
  logic [5:0] status;

  always_comb begin
    status                    = '0;
    status[UART_ST_RX_AVAIL]  = !rx_empty;
    status[UART_ST_RX_FULL]   = rx_full;
    status[UART_ST_TX_FULL]   = tx_full;
    status[UART_ST_TX_IDLE]   = tx_empty && (tx_state == S_IDLE);
    status[UART_ST_OVERRUN]   = overrun;
    status[UART_ST_FRAME_ERR] = frame_err;
  end

  always_comb begin
    rdata_o = '0;
    if (sel_i && re_i) begin
      if (reg_i)          rdata_o = {26'h0, status};
      else if (!rx_empty) rdata_o = {24'h0, rx_dout};
    end
  end

endmodule

// File: tb/tb_mmap_uart.sv
// Directed bench for mmap_uart at a reduced bit period (DIV = 40) so that
// multi-frame scenarios stay short.
module tb_mmap_uart;

  localparam int CLK_FREQ = 4_000_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = 40;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        sel_i   = 1'b0;
  logic        reg_i   = 1'b0;
  logic        we_i    = 1'b0;
  logic        re_i    = 1'b0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        rx_i;
  logic        tx_o;
  logic        loop_en = 1'b0;
  logic        rx_drv  = 1'b1;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  assign rx_i = loop_en ? tx_o : rx_drv;

  mmap_uart #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .sel_i(sel_i), .reg_i(reg_i), .we_i(we_i),
    .re_i(re_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .rx_i(rx_i), .tx_o(tx_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic r, input logic [31:0] d);
    @(negedge clk); sel_i = 1'b1; we_i = 1'b1; reg_i = r; wdata_i = d;
    @(negedge clk); sel_i = 1'b0; we_i = 1'b0; wdata_i = '0;
  endtask

  task automatic bus_read(input logic r, output logic [31:0] d);
    @(negedge clk); sel_i = 1'b1; re_i = 1'b1; reg_i = r;
    #1 d = rdata_o;
    @(negedge clk); sel_i = 1'b0; re_i = 1'b0;
  endtask

  task automatic check_status(input string name, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(1'b1, d);
    checks++;
    if (d !== exp) begin
      errors++;
      $display("FAIL %s: status got %h expected %h", name, d, exp);
    end
  endtask

  task automatic send_rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      rx_drv = bits[k];
      repeat (DIV) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  // Independent serial decoder for tx_o, sampling each bit at its middle.
  task automatic decode_tx(output logic [7:0] b, output logic ok);
    int n;
    ok = 1'b0;
    b  = '0;
    n  = 0;
    while (tx_o !== 1'b0 && n < 20 * DIV) begin
      @(negedge clk);
      n++;
    end
    if (tx_o !== 1'b0) return;
    repeat (DIV / 2) @(negedge clk);
    if (tx_o !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(negedge clk);
      b[i] = tx_o;
    end
    repeat (DIV) @(negedge clk);
    ok = (tx_o === 1'b1);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    logic [31:0] d;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx: got %b expected 1", tx_o);
    end
    check_status("reset_status", 32'h08);
    bus_read(1'b0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_data_read: got %h expected 0", d);
    end
  endtask

  task automatic test_tx_single;
    logic [9:0] frame;
    logic       idle_at_end;
    int         bad;
    frame       = {1'b1, 8'h55, 1'b0};
    idle_at_end = 1'b1;
    @(negedge clk); sel_i = 1'b1; we_i = 1'b1; reg_i = 1'b0; wdata_i = 32'h55;
    @(negedge clk);
    we_i = 1'b0; re_i = 1'b1; reg_i = 1'b1; wdata_i = '0;
    #1 checks++;
    if (tx_o !== 1'b1) begin
      errors++;
      $display("FAIL tx_pre_start: got %b expected 1", tx_o);
    end
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      bad = 0;
      for (int j = 0; j < DIV; j++) begin
        #1 if (tx_o !== frame[k]) bad++;
        if (k == 9 && j == DIV - 1) idle_at_end = rdata_o[3];
        @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL tx_bit%0d: %0d cycles wrong, expected level %b", k, bad, frame[k]);
      end
    end
    #1 checks++;
    if (rdata_o !== 32'h08) begin
      errors++;
      $display("FAIL tx_idle_after_frame: status got %h expected 00000008", rdata_o);
    end
    checks++;
    if (idle_at_end !== 1'b0) begin
      errors++;
      $display("FAIL tx_busy_in_stop: tx_idle got %b expected 0", idle_at_end);
    end
    sel_i = 1'b0; re_i = 1'b0;
  endtask

  task automatic test_loopback;
    logic [31:0] d;
    logic [7:0]  e;
    loop_en = 1'b1;
    bus_write(1'b0, 32'hA3); exp_q.push_back(8'hA3);
    bus_write(1'b0, 32'h0F); exp_q.push_back(8'h0F);
    repeat (21 * DIV) @(negedge clk);
    check_status("loop_status_avail", 32'h09);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      bus_read(1'b0, d);
      checks++;
      if (d !== {24'h0, e}) begin
        errors++;
        $display("FAIL loop_data%0d: got %h expected %h", i, d, e);
      end
    end
    check_status("loop_status_empty", 32'h08);
    loop_en = 1'b0;
  endtask

  task automatic test_frame_err;
    send_rx_frame(8'h5A, 1'b0);
    repeat (DIV) @(negedge clk);
    check_status("frame_err_set", 32'h28);
    bus_write(1'b1, 32'h00);
    check_status("frame_err_write0_keeps", 32'h28);
    bus_write(1'b1, 32'h20);
    check_status("frame_err_cleared", 32'h08);
  endtask

  task automatic test_glitch;
    @(negedge clk); rx_drv = 1'b0;
    repeat (DIV / 4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (DIV) @(negedge clk);
    check_status("glitch_no_effect", 32'h08);
  endtask

  task automatic test_overrun;
    logic [31:0] d;
    logic [7:0]  e;
    for (int i = 0; i < 9; i++) begin
      send_rx_frame(8'h30 + 8'(i), 1'b1);
      if (i < 8) exp_q.push_back(8'h30 + 8'(i));
    end
    repeat (DIV) @(negedge clk);
    check_status("overrun_set", 32'h1B);
    bus_write(1'b1, 32'h10);
    check_status("overrun_cleared", 32'h0B);
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      bus_read(1'b0, d);
      checks++;
      if (d !== {24'h0, e}) begin
        errors++;
        $display("FAIL overrun_data%0d: got %h expected %h", i, d, e);
      end
    end
    check_status("overrun_drained", 32'h08);
  endtask

  task automatic test_tx_full;
    logic [7:0] b;
    logic [7:0] e;
    logic       ok;
    int         lows;
    fork
      begin
        @(negedge clk); sel_i = 1'b1; we_i = 1'b1; reg_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
          wdata_i = 32'hC0 + 32'(i);
          exp_q.push_back(8'hC0 + 8'(i));
          @(negedge clk);
        end
        we_i = 1'b0; re_i = 1'b1; reg_i = 1'b1; wdata_i = '0;
        #1 checks++;
        if (rdata_o !== 32'h04) begin
          errors++;
          $display("FAIL tx_full_flag: status got %h expected 00000004", rdata_o);
        end
        @(negedge clk); sel_i = 1'b0; re_i = 1'b0;
        bus_write(1'b0, 32'hEE);
      end
      begin
        for (int n = 0; n < 9; n++) begin
          decode_tx(b, ok);
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
          checks++;
          if (!ok || b !== e) begin
            errors++;
            $display("FAIL tx_full_byte%0d: got %h (framing ok=%b) expected %h", n, b, ok, e);
          end
        end
      end
    join
    lows = 0;
    repeat (12 * DIV) begin
      @(negedge clk);
      if (tx_o !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin
      errors++;
      $display("FAIL tx_full_dropped: %0d low cycles after 9 frames, expected 0", lows);
    end
    check_status("tx_full_done", 32'h08);
  endtask

  task automatic test_reset_mid_frame;
    int lows;
    bus_write(1'b0, 32'h00);
    repeat (3 * DIV) @(negedge clk);
    checks++;
    if (tx_o !== 1'b0) begin
      errors++;
      $display("FAIL midframe_low: got %b expected 0", tx_o);
    end
    #3 rst_n = 1'b0;
    #1 checks++;
    if (tx_o !== 1'b1) begin
      errors++;
      $display("FAIL midframe_async_reset: got %b expected 1", tx_o);
    end
    @(negedge clk); rst_n = 1'b1;
    lows = 0;
    repeat (11 * DIV) begin
      @(negedge clk);
      if (tx_o !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin
      errors++;
      $display("FAIL midframe_aborted: %0d low cycles after reset, expected 0", lows);
    end
    check_status("midframe_status", 32'h08);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset;
    test_tx_single;
    test_loopback;
    test_frame_err;
    test_glitch;
    test_overrun;
    test_tx_full;
    test_reset_mid_frame;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
